// File: rtl/rggen_axi4lite_adapter.sv
// AXI4-Lite slave front end for a generated register block.
// Accepts AXI4-Lite reads and writes, arbitrates between them, and issues one
// request at a time on the shared register bus. The response comes from the
// selected register's ready, status and read data.
//
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_aw*/o_awready, i_w*/o_wready write address / data channels (accepted together)
//   o_b*/i_bready                  write response channel
//   i_ar*/o_arready                read address channel
//   o_r*/i_rready                  read data/response channel
//   o_register_*                   request to all register instances
//   i_register_*                   per-register active/ready/status/read data
module rggen_axi4lite_adapter #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned BUS_WIDTH     = 32,
    parameter int unsigned REGISTERS     = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_awvalid,
    output logic                           o_awready,
    input  logic [ADDRESS_WIDTH-1:0]       i_awaddr,
    input  logic [2:0]                     i_awprot,
    input  logic                           i_wvalid,
    output logic                           o_wready,
    input  logic [BUS_WIDTH-1:0]           i_wdata,
    input  logic [BUS_WIDTH/8-1:0]         i_wstrb,
    output logic                           o_bvalid,
    input  logic                           i_bready,
    output logic [1:0]                     o_bresp,
    input  logic                           i_arvalid,
    output logic                           o_arready,
    input  logic [ADDRESS_WIDTH-1:0]       i_araddr,
    input  logic [2:0]                     i_arprot,
    output logic                           o_rvalid,
    input  logic                           i_rready,
    output logic [BUS_WIDTH-1:0]           o_rdata,
    output logic [1:0]                     o_rresp,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int unsigned StrbWidth = BUS_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] AlignMask = ~ADDRESS_WIDTH'(StrbWidth - 1);
    localparam logic [1:0] AccessRead  = 2'b10;
    localparam logic [1:0] AccessWrite = 2'b11;
    localparam logic [1:0] RespDecerr  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResponse
    } state_e;

    state_e                   state_q, state_d;
    logic                     last_write_q;  // 0: last grant was a read
    logic [1:0]               access_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [BUS_WIDTH-1:0]     strobe_q;
    logic [1:0]               resp_q;
    logic [BUS_WIDTH-1:0]     read_data_q;

    logic                     grant_write, grant_read;
    logic                     is_write;
    logic [REGISTERS-1:0]     selected;
    logic                     hit, no_hit;
    logic [1:0]               sel_status;
    logic [BUS_WIDTH-1:0]     sel_data;
    logic [BUS_WIDTH-1:0]     bit_strobe;

    // Protection attributes carry no meaning for this block.
    logic unused_prot;
    assign unused_prot = ^{i_awprot, i_arprot};

    assign is_write = (access_q == AccessWrite);
    assign selected = i_register_active & i_register_ready;
    assign hit      = |selected;
    assign no_hit   = ~|i_register_active;

    always_comb begin
        sel_status = '0;
        sel_data   = '0;
        for (int i = 0; i < int'(REGISTERS); i++) begin
            if (selected[i]) begin
                sel_status = sel_status | i_register_status[2*i +: 2];
                sel_data   = sel_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    always_comb begin
        bit_strobe = '0;
        for (int i = 0; i < int'(StrbWidth); i++) begin
            bit_strobe[8*i +: 8] = {8{i_wstrb[i]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_write = 1'b0;
        grant_read  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // AW and W are only ever accepted as a pair; on conflict alternate.
                grant_write = i_awvalid && i_wvalid && (!i_arvalid || !last_write_q);
                grant_read  = i_arvalid && !grant_write;
                if (grant_write || grant_read) state_d = StBusy;
            end
            StBusy: begin
                if (hit || no_hit) state_d = StResponse;
            end
            StResponse: begin
                if ((is_write && i_bready) || (!is_write && i_rready)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Gate grants with reset so every output reads 0 while reset is held.
    assign o_awready = grant_write && !i_rst;
    assign o_wready  = grant_write && !i_rst;
    assign o_arready = grant_read && !i_rst;

    assign o_register_valid      = (state_q == StBusy);
    assign o_register_access     = access_q;
    assign o_register_address    = address_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;

    assign o_bvalid = (state_q == StResponse) && is_write;
    assign o_rvalid = (state_q == StResponse) && !is_write;
    assign o_bresp  = resp_q;
    assign o_rresp  = resp_q;
    assign o_rdata  = read_data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            last_write_q <= 1'b0;
            access_q     <= 2'b00;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            resp_q       <= 2'b00;
            read_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_write) begin
                last_write_q <= 1'b1;
                access_q     <= AccessWrite;
                address_q    <= i_awaddr & AlignMask;
                write_data_q <= i_wdata;
                strobe_q     <= bit_strobe;
            end else if (grant_read) begin
                last_write_q <= 1'b0;
                access_q     <= AccessRead;
                address_q    <= i_araddr & AlignMask;
                write_data_q <= '0;
                strobe_q     <= '0;
            end
            if (state_q == StBusy) begin
                if (hit) begin
                    resp_q      <= sel_status;
                    read_data_q <= is_write ? '0 : sel_data;
                end else if (no_hit) begin
                    resp_q      <= RespDecerr;
                    read_data_q <= '0;
                end
            end
        end
    end

endmodule
